// File: rtl/sd_spi_responder_if.sv
// SPI link (CS/D1/D0) and block-read memory port of the SD SPI responder.
// master = host plus backing memory, slave = responder.
interface sd_spi_responder_if;
   logic        CS;
   logic        D1;
   logic        D0;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;

   modport master (output CS, output D1, input D0,
                   input mem_addr, input mem_rd, output mem_data);
   modport slave  (input CS, input D1, output D0,
                   output mem_addr, output mem_rd, input mem_data);
endinterface

// File: rtl/sd_spi_responder.sv
// SD card SPI-mode responder: CMD0/8/16/17/55 and ACMD41 with single-block reads.
// D0 is a registered MSB-first stream that leaves no gaps between fields.
module sd_spi_responder #(
   parameter int unsigned INIT_POLLS = 2,
   parameter int unsigned NCR_BYTES  = 1,
   parameter int unsigned NAC_BYTES  = 2
) (
   input  logic               clk,
   input  logic               reset,
   sd_spi_responder_if.slave  bus,
   output logic               card_ready,
   output logic [3:0]         cur_state
);
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned POLL_W = 8;
   localparam int unsigned LEN_W  = 5;

   typedef enum logic [3:0] {
      WAIT_START = 4'd0, RX_CMD = 4'd1, DECODE = 4'd2, NCR = 4'd3, TX_R1 = 4'd4,
      TX_R7 = 4'd5, NAC = 4'd6, TX_TOKEN = 4'd7, TX_DATA = 4'd8, TX_CRC = 4'd9
   } state_t;

   state_t            state;
   logic [47:0]       rx_sr;
   logic [31:0]       tx_sr;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [LEN_W-1:0]  blk_len;
   logic [LEN_W-1:0]  bytes_left;
   logic [POLL_W-1:0] poll_cnt;
   logic              app_cmd;
   logic              rd_cap;
   logic [7:0]        data_buf;
   logic [7:0]        r1_reg;
   logic              send_r7;
   logic              do_read;

   logic [5:0]        cmd_idx;
   logic [31:0]       cmd_arg;
   logic              frame_ok;
   logic              len_ok;
   logic [POLL_W-1:0] poll_inc;
   logic              dec_illegal;
   logic              dec_param;
   logic              dec_r7;
   logic              dec_read;
   logic              nxt_ready;
   logic [7:0]        dec_r1;

   // rx_sr holds the whole frame until the next start bit, so cmd_arg stays valid for R7/read.
   assign cmd_idx   = rx_sr[45:40];
   assign cmd_arg   = rx_sr[39:8];
   assign frame_ok  = ~rx_sr[47] & rx_sr[46] & rx_sr[0];
   assign len_ok    = (cmd_arg >= 32'd1) && (cmd_arg <= 32'd16);
   assign poll_inc  = (poll_cnt >= POLL_W'(INIT_POLLS)) ? poll_cnt : poll_cnt + POLL_W'(1);
   assign cur_state = state;

   // Command decode; idle in R1 reflects the ready state after this command.
   always_comb begin
      dec_illegal = 1'b0;
      dec_param   = 1'b0;
      dec_r7      = 1'b0;
      dec_read    = 1'b0;
      nxt_ready   = card_ready;
      case (cmd_idx)
         6'd0:  nxt_ready = 1'b0;
         6'd8:  dec_r7 = 1'b1;
         6'd55: begin end
         6'd41: begin
            if (!app_cmd) dec_illegal = 1'b1;
            else if (poll_inc >= POLL_W'(INIT_POLLS)) nxt_ready = 1'b1;
         end
         6'd16: begin
            if (!card_ready) dec_illegal = 1'b1;
            else if (!len_ok) dec_param = 1'b1;
         end
         6'd17: begin
            if (!card_ready) dec_illegal = 1'b1;
            else dec_read = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      dec_r1 = {1'b0, dec_param, 3'b000, dec_illegal, 1'b0, ~nxt_ready};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= WAIT_START;
         bus.D0       <= 1'b1;
         bus.mem_rd   <= 1'b0;
         bus.mem_addr <= '0;
         card_ready   <= 1'b0;
         app_cmd      <= 1'b0;
         poll_cnt     <= '0;
         blk_len      <= LEN_W'(4);
         rx_sr        <= '0;
         tx_sr        <= '1;
         cnt          <= '0;
         bit_idx      <= '0;
         bytes_left   <= '0;
         rd_cap       <= 1'b0;
         data_buf     <= '0;
         r1_reg       <= '1;
         send_r7      <= 1'b0;
         do_read      <= 1'b0;
      end else begin
         bus.mem_rd <= 1'b0;
         rd_cap     <= bus.mem_rd;
         if (rd_cap) data_buf <= bus.mem_data;
         if (bus.CS) begin
            state  <= WAIT_START;
            bus.D0 <= 1'b1;
         end else begin
            case (state)
               WAIT_START: begin
                  bus.D0 <= 1'b1;
                  if (!bus.D1) begin
                     state <= RX_CMD;
                     rx_sr <= '0;
                     cnt   <= CNT_W'(46);
                  end
               end
               RX_CMD: begin
                  rx_sr <= {rx_sr[46:0], bus.D1};
                  if (cnt == '0) state <= DECODE;
                  else cnt <= cnt - CNT_W'(1);
               end
               DECODE: begin
                  if (!frame_ok) begin
                     state <= WAIT_START;
                  end else begin
                     state      <= NCR;
                     bus.D0     <= 1'b1;
                     cnt        <= CNT_W'(NCR_BYTES * 8 - 1);
                     r1_reg     <= dec_r1;
                     send_r7    <= dec_r7;
                     do_read    <= dec_read;
                     card_ready <= nxt_ready;
                     app_cmd    <= (cmd_idx == 6'd55);
                     if (cmd_idx == 6'd0) poll_cnt <= '0;
                     if (cmd_idx == 6'd41 && app_cmd) poll_cnt <= poll_inc;
                     if (cmd_idx == 6'd16 && card_ready && len_ok) blk_len <= LEN_W'(cmd_arg);
                  end
               end
               NCR: begin
                  if (cnt != '0) begin
                     bus.D0 <= 1'b1;
                     cnt    <= cnt - CNT_W'(1);
                  end else begin
                     state  <= TX_R1;
                     bus.D0 <= r1_reg[7];
                     tx_sr  <= {r1_reg[6:0], 25'h1FF_FFFF};
                     cnt    <= CNT_W'(7);
                  end
               end
               TX_R1: begin
                  if (cnt != '0) begin
                     bus.D0 <= tx_sr[31];
                     tx_sr  <= {tx_sr[30:0], 1'b1};
                     cnt    <= cnt - CNT_W'(1);
                  end else if (send_r7) begin
                     state  <= TX_R7;
                     bus.D0 <= cmd_arg[31];
                     tx_sr  <= {cmd_arg[30:0], 1'b1};
                     cnt    <= CNT_W'(31);
                  end else if (do_read) begin
                     state  <= NAC;
                     bus.D0 <= 1'b1;
                     cnt    <= CNT_W'(NAC_BYTES * 8 - 1);
                  end else begin
                     state  <= WAIT_START;
                     bus.D0 <= 1'b1;
                  end
               end
               TX_R7: begin
                  if (cnt != '0) begin
                     bus.D0 <= tx_sr[31];
                     tx_sr  <= {tx_sr[30:0], 1'b1};
                     cnt    <= cnt - CNT_W'(1);
                  end else begin
                     state  <= WAIT_START;
                     bus.D0 <= 1'b1;
                  end
               end
               NAC: begin
                  bus.D0 <= 1'b1;
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_W'(1);
                  end else begin
                     state <= TX_TOKEN;
                     tx_sr <= {7'b111_1110, 25'h1FF_FFFF};
                     cnt   <= CNT_W'(7);
                  end
               end
               TX_TOKEN: begin
                  // Prefetch byte 0 so it is in data_buf before the token ends.
                  if (cnt == CNT_W'(5)) begin
                     bus.mem_rd   <= 1'b1;
                     bus.mem_addr <= cmd_arg;
                  end
                  if (cnt != '0) begin
                     bus.D0 <= tx_sr[31];
                     tx_sr  <= {tx_sr[30:0], 1'b1};
                     cnt    <= cnt - CNT_W'(1);
                  end else begin
                     state      <= TX_DATA;
                     bus.D0     <= data_buf[7];
                     tx_sr      <= {data_buf[6:0], 25'h1FF_FFFF};
                     bit_idx    <= 3'd7;
                     bytes_left <= blk_len - LEN_W'(1);
                  end
               end
               TX_DATA: begin
                  if (bit_idx == 3'd5 && bytes_left != '0) begin
                     bus.mem_rd   <= 1'b1;
                     bus.mem_addr <= bus.mem_addr + 32'd1;
                  end
                  bit_idx <= bit_idx - 3'd1;
                  if (bit_idx != 3'd0) begin
                     bus.D0 <= tx_sr[31];
                     tx_sr  <= {tx_sr[30:0], 1'b1};
                  end else if (bytes_left != '0) begin
                     bus.D0     <= data_buf[7];
                     tx_sr      <= {data_buf[6:0], 25'h1FF_FFFF};
                     bytes_left <= bytes_left - LEN_W'(1);
                  end else begin
                     state  <= TX_CRC;
                     bus.D0 <= 1'b1;
                     cnt    <= CNT_W'(15);
                  end
               end
               TX_CRC: begin
                  bus.D0 <= 1'b1;
                  if (cnt != '0) cnt <= cnt - CNT_W'(1);
                  else state <= WAIT_START;
               end
               default: begin
                  state  <= WAIT_START;
                  bus.D0 <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: drives command frames on D1 and checks
// the D0 bit stream, memory reads and status against hand-computed values.
module tb_sd_spi_responder;
   logic       clk;
   logic       reset;
   logic       card_ready;
   logic [3:0] cur_state;

   sd_spi_responder_if bus ();

   sd_spi_responder dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .card_ready (card_ready),
      .cur_state  (cur_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory: A1 B2 C3 D4 at offsets 0..3, bitwise-inverted offset elsewhere.
   logic [7:0] mem [0:255];
   always @(posedge clk)
      if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr[7:0]];

   int          n_cmp;
   int          n_err;
   logic        rsp    [0:299];
   logic [3:0]  st_log [0:299];
   logic [31:0] rd_addr [0:15];
   int          rd_n;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, 7'h4A, 1'b1};
   endfunction

   function automatic logic [7:0] get_byte(input int p);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[6:0], rsp[p + i]};
      return r;
   endfunction

   function automatic logic [31:0] get_word(input int p);
      return {get_byte(p), get_byte(p + 8), get_byte(p + 16), get_byte(p + 24)};
   endfunction

   function automatic int zeros(input int from, input int upto);
      int z;
      z = 0;
      for (int i = from; i <= upto; i++) if (rsp[i] == 1'b0) z++;
      return z;
   endfunction

   // Slot k: D0 sampled on the k-th negedge, then D1 (frame bit k) is driven for posedge k.
   task automatic run_frame(input logic [47:0] fr, input int ncyc, input int cs_at, input int rst_at);
      logic stop;
      stop = 1'b0;
      rd_n = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         rsp[k]    = bus.D0;
         st_log[k] = cur_state;
         if (bus.mem_rd) begin
            if (rd_n < 16) rd_addr[rd_n] = bus.mem_addr;
            rd_n++;
         end
         bus.CS = (cs_at >= 0 && k >= cs_at);
         reset  = (k == rst_at);
         if (k == rst_at) stop = 1'b1;
         bus.D1 = (k < 48 && !stop) ? fr[47 - k] : 1'b1;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
      mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;

      reset  = 1'b1;
      bus.CS = 1'b1;
      bus.D1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_d0", 64'(bus.D0), 64'd1);
      chk("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_ready", 64'(card_ready), 64'd0);
      chk("rst_state", 64'(cur_state), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // CMD0: 8 NCR ones then R1 0x01, idle high afterwards
      run_frame(48'h40_0000_0000_95, 80, -1, -1);
      chk("cmd0_ncr", 64'(get_byte(49)), 64'hFF);
      chk("cmd0_r1", 64'(get_byte(57)), 64'h01);
      chk("cmd0_after", 64'(get_byte(65)), 64'hFF);

      // CMD8 echoes its argument in R7
      run_frame(mk(6'd8, 32'h0000_01AA), 105, -1, -1);
      chk("cmd8_r1", 64'(get_byte(57)), 64'h01);
      chk("cmd8_r7", 64'(get_word(65)), 64'h0000_01AA);
      chk("cmd8_after", 64'(get_byte(97)), 64'hFF);

      // Invalid transmission bit: no response at all
      run_frame(48'h00_0000_0000_95, 80, -1, -1);
      chk("badframe_quiet", 64'(zeros(48, 79)), 64'd0);

      // ACMD41 without CMD55, and CMD17 before init
      run_frame(mk(6'd41, 32'h0), 80, -1, -1);
      chk("acmd41_noapp_r1", 64'(get_byte(57)), 64'h05);
      run_frame(mk(6'd17, 32'h100), 110, -1, -1);
      chk("cmd17_idle_r1", 64'(get_byte(57)), 64'h05);
      chk("cmd17_idle_notoken", 64'(zeros(65, 109)), 64'd0);
      chk("cmd17_idle_noread", 64'(rd_n), 64'd0);

      // Two CMD55+ACMD41 rounds reach ready
      run_frame(mk(6'd55, 32'h0), 80, -1, -1);
      chk("cmd55a_r1", 64'(get_byte(57)), 64'h01);
      run_frame(mk(6'd41, 32'h4000_0000), 80, -1, -1);
      chk("acmd41a_r1", 64'(get_byte(57)), 64'h01);
      chk("acmd41a_ready", 64'(card_ready), 64'd0);
      run_frame(mk(6'd55, 32'h0), 80, -1, -1);
      chk("cmd55b_r1", 64'(get_byte(57)), 64'h01);
      run_frame(mk(6'd41, 32'h4000_0000), 80, -1, -1);
      chk("acmd41b_r1", 64'(get_byte(57)), 64'h00);
      chk("acmd41b_ready", 64'(card_ready), 64'd1);

      // CMD16 len 4 then CMD17 at 0x100
      run_frame(mk(6'd16, 32'd4), 80, -1, -1);
      chk("cmd16_4_r1", 64'(get_byte(57)), 64'h00);
      run_frame(mk(6'd17, 32'h100), 145, -1, -1);
      chk("rd_r1", 64'(get_byte(57)), 64'h00);
      chk("rd_nac", 64'({get_byte(65), get_byte(73)}), 64'hFFFF);
      chk("rd_token", 64'(get_byte(81)), 64'hFE);
      chk("rd_data", 64'(get_word(89)), 64'hA1B2_C3D4);
      chk("rd_crc", 64'({get_byte(121), get_byte(129)}), 64'hFFFF);
      chk("rd_after", 64'(get_byte(137)), 64'hFF);
      chk("rd_state_data", 64'(st_log[90]), 64'd8);
      chk("rd_count", 64'(rd_n), 64'd4);
      for (int i = 0; i < 4; i++) chk("rd_addr", 64'(rd_addr[i]), 64'(32'h100 + 32'(i)));

      // CMD16 arg 0 rejected, blk_len stays 4
      run_frame(mk(6'd16, 32'd0), 80, -1, -1);
      chk("cmd16_0_r1", 64'(get_byte(57)), 64'h40);
      run_frame(mk(6'd17, 32'h104), 145, -1, -1);
      chk("len4_count", 64'(rd_n), 64'd4);
      chk("len4_data", 64'(get_word(89)), 64'hFBFA_F9F8);

      // blk_len 2 with address wrap past 0xFFFFFFFF
      run_frame(mk(6'd16, 32'd2), 80, -1, -1);
      chk("cmd16_2_r1", 64'(get_byte(57)), 64'h00);
      run_frame(mk(6'd17, 32'hFFFF_FFFF), 130, -1, -1);
      chk("wrap_data", 64'({get_byte(89), get_byte(97)}), 64'h00A1);
      chk("wrap_crc", 64'({get_byte(105), get_byte(113)}), 64'hFFFF);
      chk("wrap_count", 64'(rd_n), 64'd2);
      chk("wrap_addr0", 64'(rd_addr[0]), 64'hFFFF_FFFF);
      chk("wrap_addr1", 64'(rd_addr[1]), 64'h0);

      // CS raised during data byte 1 abandons the block
      run_frame(mk(6'd16, 32'd4), 80, -1, -1);
      run_frame(mk(6'd17, 32'h100), 110, 98, -1);
      chk("cs_r1", 64'(get_byte(57)), 64'h00);
      chk("cs_state", 64'(st_log[99]), 64'd0);
      chk("cs_d0", 64'(rsp[99]), 64'd1);
      chk("cs_quiet", 64'(zeros(99, 109)), 64'd0);
      chk("cs_reads", 64'(rd_n), 64'd2);
      chk("cs_ready_kept", 64'(card_ready), 64'd1);

      // Reset in the middle of a command frame
      run_frame(mk(6'd8, 32'h0000_01AA), 80, -1, 20);
      chk("rstmid_quiet", 64'(zeros(21, 79)), 64'd0);
      chk("rstmid_ready", 64'(card_ready), 64'd0);
      chk("rstmid_addr", 64'(bus.mem_addr), 64'd0);
      chk("rstmid_state", 64'(cur_state), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter: INIT_POLLS, default 2, number of ACMD41 commands after CMD0 until the card reports ready (R1=0x00).
REQ-002 Parameter: NCR_BYTES, default 1, number of 0xFF bytes between the command end bit and the R1 response.
REQ-003 Parameter: NAC_BYTES, default 2, number of 0xFF bytes between the CMD17 R1 and the 0xFE data token.
REQ-004 clk  in  1  SD bit clock; one MOSI/MISO bit per rising edge. One clock only.
REQ-005 reset  in  1  Reset. Synchronous, active-high.
REQ-006 CS  in  1  Chip select, active low.
REQ-007 D1  in  1  MOSI, the command stream from the host; sampled on posedge clk.
REQ-008 D0  out  1  MISO, the response stream to the host; registered and MSB-first.
REQ-009 mem_addr  out  32  Byte address of the block read.
REQ-010 mem_rd  out  1  Read strobe, one cycle per byte.
REQ-011 mem_data  in  8  Read data, valid on the cycle after mem_rd.
REQ-012 card_ready  out  1  High once ACMD41 has returned 0x00.
REQ-013 cur_state  out  4  Current FSM state encoding, for debug.

Function
REQ-014 FSM states: WAIT_START, RX_CMD, DECODE, NCR, TX_R1, TX_R7, NAC, TX_TOKEN, TX_DATA, TX_CRC.
REQ-015 WAIT_START: D0=1. The first D1=0 sampled while CS=0 is the start bit. The FSM then goes to RX_CMD and captures the remaining 47 bits into a 48-bit shift register, MSB first.
REQ-016 After bit 48, DECODE (one cycle):
- cmd index = bits[45:40]; arg = bits[39:8].
- Transmission bit (bit46) must be 1 and end bit (bit0) must be 1; otherwise discard and return to WAIT_START with no response.
- The CRC field is ignored.
REQ-017 R1 = {1'b0, param_err, 3'b000, illegal, 1'b0, idle}. idle = NOT card_ready.
REQ-018 Command handling:
- CMD0: card_ready=0, app_cmd=0, poll count=0; R1=0x01.
- CMD8: R1 followed by R7. R7 = 32-bit arg echoed unchanged.
- CMD55: sets app_cmd=1.
- ACMD41 (index 41 with app_cmd=1): increments the poll count. Once the count reaches INIT_POLLS, card_ready=1 and R1=0x00.
- CMD16: arg in 1..16 sets blk_len; otherwise param_err=1 and blk_len is unchanged.
- CMD17 with card_ready=1: R1=0x00, then the read sequence.
- Any other index, index 41 without app_cmd, or CMD16/CMD17 while idle: illegal=1.
REQ-019 app_cmd is cleared by every decoded command except CMD55.
REQ-020 NCR: shift out NCR_BYTES*8 ones. TX_R1: shift out 8 bits. TX_R7: shift out 32 bits. After the last bit, return to WAIT_START, or go to NAC for a successful CMD17.
REQ-021 Read sequence:
- NAC_BYTES of 0xFF.
- Token 0xFE.
- blk_len bytes from mem_addr = arg + i, i = 0..blk_len-1, 32-bit wrap on overflow.
- 16 ones as the CRC field.
- Return to WAIT_START.
REQ-022 mem_rd pulses exactly once per byte, at least 2 cycles before that byte's first bit. There is never a gap between bytes on D0.
REQ-023 Commands on D1 during any TX state are ignored. The bit counter is reloaded per field, and a 3-bit bit index wraps 7->0 per byte.
REQ-024 CS high in any state: next cycle the FSM is in WAIT_START with D0=1. Any partial command or transfer is abandoned. card_ready, blk_len and the poll count are retained.
REQ-025 blk_len resets to 4.

Reset
REQ-026 When reset=1 on a clk edge:
- FSM = WAIT_START; D0=1.
- mem_rd=0; mem_addr=0.
- card_ready=0; app_cmd=0; poll count=0; blk_len=4.
- cur_state=WAIT_START encoding.
REQ-027 Reset overrides CS and D1. It aborts any operation in progress, including mid-data-block.

Verification
REQ-028 CMD0 frame 0x40_00000000_95 -> 8 ones, then R1 0x01; D0 high afterwards.
REQ-029 CMD8 arg 0x000001AA -> R1 0x01 then 0x000001AA on D0.
REQ-030 CMD55+ACMD41 twice (INIT_POLLS=2) -> R1 0x01 first, then 0x00 with card_ready=1. Also, ACMD41 without a preceding CMD55 -> R1 0x05.
REQ-031 CMD16 arg 4 -> 0x00, then CMD17 arg 0x100 with memory bytes A1 B2 C3 D4 -> R1 0x00, 16 ones, 0xFE, A1 B2 C3 D4, 0xFFFF; mem_addr 0x100..0x103.
REQ-032 CMD16 arg 0 -> R1 0x40 and blk_len stays 4. Also, CMD17 before init -> R1 0x05 and no token.
REQ-033 CS raised mid-data-block -> next cycle WAIT_START, D0=1, no further mem_rd. Also, reset mid-RX_CMD -> no response.
